// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]         op;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               last;

  logic               in_div;
  logic               in_sdiv;
  logic               in_neg_a;
  logic               in_neg_b;

  logic [CW-1:0]      bit_idx;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rem_nxt;
  logic [2*WIDTH-1:0] div_step;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   a_orig;
  logic               b_zero;
  logic [WIDTH-1:0]   fin_res;

  assign last = (cnt == CW'(WIDTH - 1));

  // Decode operand signedness from the request being issued
  always_comb begin
    in_div   = funct3[2];
    in_sdiv  = funct3[2] & ~funct3[0];
    in_neg_a = 1'b0;
    in_neg_b = 1'b0;
    if (in_div) begin
      in_neg_a = in_sdiv & a[WIDTH-1];
      in_neg_b = in_sdiv & b[WIDTH-1];
    end else begin
      in_neg_a = a[WIDTH-1] &
        ((funct3[1:0] == 2'b01) |
         (funct3[1:0] == 2'b10));
      in_neg_b = b[WIDTH-1] &
        (funct3[1:0] == 2'b01);
    end
  end

  // One MSB-first iteration of multiply and divide
  always_comb begin
    bit_idx  = CW'(WIDTH - 1) - cnt;
    mul_step = {acc[2*WIDTH-2:0], 1'b0};
    if (mag_b[bit_idx])
      mul_step = mul_step + {{WIDTH{1'b0}}, mag_a};
    trial    = {acc[2*WIDTH-1:WIDTH],
                mag_a[bit_idx]};
    ge       = trial >= {1'b0, mag_b};
    diff     = trial[WIDTH-1:0] - mag_b;
    rem_nxt  = ge ? diff : trial[WIDTH-1:0];
    div_step = {rem_nxt, acc[WIDTH-2:0], ge};
  end

  // Sign correction and result select; the signed
  // overflow case falls out of the magnitude math
  always_comb begin
    prod    = (neg_a ^ neg_b) ? -acc : acc;
    quo     = (neg_a ^ neg_b) ? -acc[WIDTH-1:0]
                              : acc[WIDTH-1:0];
    rem     = neg_a ? -acc[2*WIDTH-1:WIDTH]
                    : acc[2*WIDTH-1:WIDTH];
    a_orig  = neg_a ? -mag_a : mag_a;
    b_zero  = (mag_b == '0);
    fin_res = '0;
    unique case (1'b1)
      (op == 3'b000):
        fin_res = prod[WIDTH-1:0];
      (~op[2] & (op != 3'b000)):
        fin_res = prod[2*WIDTH-1:WIDTH];
      (op[2] & ~op[1] & b_zero):
        fin_res = '1;
      (op[2] & op[1] & b_zero):
        fin_res = a_orig;
      (op[2] & ~op[1] & ~b_zero):
        fin_res = quo;
      (op[2] & op[1] & ~b_zero):
        fin_res = rem;
      default:
        fin_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == FIN);
      unique case (state)
        IDLE: begin
          if (start) begin
            op    <= funct3;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            mag_a <= in_neg_a ? -a : a;
            mag_b <= in_neg_b ? -b : b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc <= op[2] ? div_step : mul_step;
          cnt <= cnt + 1'b1;
        end
        FIN: begin
          result <= fin_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed ops checked against
// literals and a per-cycle arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference RV32M semantics in plain arithmetic
  function automatic logic [31:0] ref_op(
    input logic [2:0]  f,
    input logic [31:0] x,
    input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] uy;
    logic [63:0]        p;
    logic [31:0]        r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    uy = {32'b0, y};
    p  = 64'h0;
    r  = 32'h0;
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFFFFFF;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          r = 32'h80000000;
        else r = $signed(x) / $signed(y);
      end
      3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          r = 32'h0;
        else r = $signed(x) % $signed(y);
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Timing model: an accepted op completes 33 edges later
  int          m_cnt  = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = 32'h0;
  logic [31:0] m_pend = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= 32'h0;
    end else if (m_cnt == 0) begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= ref_op(funct3, a, b);
        m_cnt  <= 33;
      end
    end else begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) m_res <= m_pend;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("busy_model", 32'(busy), 32'(m_cnt != 0));
    check("done_model", 32'(done), 32'(m_done));
    check("result_model", result, m_res);
  end

  task automatic run_op(input string name,
                        input logic [2:0] f,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] exp);
    int cyc;
    int bcnt;
    start  = 1'b1;
    funct3 = f;
    a      = x;
    b      = y;
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    cyc    = 0;
    bcnt   = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!done && busy) bcnt++;
    end
    check(name, result, exp);
    check({name, "_lat"}, 32'(cyc), 32'd33);
    check({name, "_busy"}, 32'(bcnt), 32'd33);
  endtask

  initial begin
    int cyc;
    int seen;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul",    3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
    run_op("mulh",   3'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'h2, 32'h00000001);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000,
           32'h40000000);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);
    run_op("divu",   3'd5, 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC);
    run_op("remu",   3'd7, 32'hFFFFFFF9, 32'h2, 32'h00000001);
    run_op("div_z",  3'd4, 32'h12345678, 32'h0, 32'hFFFFFFFF);
    run_op("remu_z", 3'd7, 32'h12345678, 32'h0, 32'h12345678);
    run_op("divu_z", 3'd5, 32'h12345678, 32'h0, 32'hFFFFFFFF);
    run_op("rem_z",  3'd6, 32'h12345678, 32'h0, 32'h12345678);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000);

    // Extra START pulses while busy must be ignored
    start = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 4 || cyc == 19);
      a = 32'd7 + 32'(cyc);
      b = 32'd9;
    end
    start = 1'b0;
    check("ignore_start", result, 32'd15);
    check("ignore_start_lat", 32'(cyc), 32'd33);

    // START held through DONE: back-to-back issue
    start = 1'b1; funct3 = 3'd4; a = 32'd100; b = 32'd7;
    @(negedge clk);
    funct3 = 3'd7; a = 32'd200; b = 32'd0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first", result, 32'h0000000E);
    check("b2b_first_lat", 32'(cyc), 32'd33);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'h1);
    check("b2b_hold", result, 32'h0000000E);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_second", result, 32'h000000C8);
    check("b2b_gap", 32'(cyc), 32'd34);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_result", result, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no_spurious_done", 32'(seen), 32'h0);
    check("post_rst_result", result, 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
